// File: rtl/sd_seq_burst_gen.sv
// rtl/sd_seq_burst_gen.sv - srdy/drdy burst/gap shaped incrementing sequence producer
// Optional SDLIB_SEQ_GEN_ERRINJ_EN adds err_inj: a flagged transfer advances seq by 2.
module sd_seq_burst_gen #(
   parameter int width      = 8,
   parameter int tag_sz     = 1,
   parameter int tag_val    = 0,
   parameter int burst_len  = 4,
   parameter int gap_cycles = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [15:0]      count,
`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
   input  logic             err_inj,
`endif
   output logic             p_srdy,
   input  logic             p_drdy,
   output logic [width-1:0] p_data,
   output logic             busy,
   output logic             done
);
   localparam int CS = width - tag_sz;
   localparam int BW = $clog2(burst_len + 1);
   localparam int GW = (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
   localparam logic [tag_sz-1:0] TAG  = tag_sz'(tag_val);
   localparam logic [BW-1:0]     BLEN = BW'(burst_len);
   localparam logic [GW-1:0]     GLEN = GW'(gap_cycles);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t          state_q, state_d;
   logic [CS-1:0]   seq_q, seq_d;
   logic [15:0]     remaining_q, remaining_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic            srdy_q, srdy_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CS-1:0]   seq_inc;

`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
   assign seq_inc = err_inj ? CS'(2) : CS'(1);
`else
   assign seq_inc = CS'(1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         seq_q       <= '0;
         remaining_q <= '0;
         burst_cnt_q <= '0;
         gap_cnt_q   <= '0;
         srdy_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         remaining_q <= remaining_d;
         burst_cnt_q <= burst_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         srdy_q      <= srdy_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      remaining_d = remaining_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      srdy_d      = srdy_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               if (count != 16'd0) begin
                  state_d     = RUN;
                  remaining_d = count;
                  burst_cnt_d = '0;
                  busy_d      = 1'b1;
                  srdy_d      = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (p_drdy) begin
               seq_d       = seq_q + seq_inc;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  // last item: finish without a trailing gap even on a burst boundary
                  state_d     = IDLE;
                  srdy_d      = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  burst_cnt_d = '0;
               end else if (burst_cnt_q + BW'(1) == BLEN) begin
                  burst_cnt_d = '0;
                  if (gap_cycles != 0) begin
                     state_d   = GAP;
                     gap_cnt_d = GLEN;
                     srdy_d    = 1'b0;
                  end
               end else begin
                  burst_cnt_d = burst_cnt_q + BW'(1);
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (gap_cnt_q == GW'(1)) begin
               state_d = RUN;
               srdy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign p_srdy = srdy_q;
   assign p_data = {TAG, seq_q};
   assign busy   = busy_q;
   assign done   = done_q;
endmodule

// File: tb/tb_sd_seq_burst_gen.sv
// tb/tb_sd_seq_burst_gen.sv - directed self-checking bench for sd_seq_burst_gen
module tb_sd_seq_burst_gen;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go1 = 1'b0, go2 = 1'b0;
   logic [15:0] count = 16'd0;
   logic        p_drdy = 1'b0;
   logic        errinj = 1'b0;
   logic        srdy1, busy1, done1, srdy2, busy2, done2;
   logic [7:0]  data1;
   logic [3:0]  data2;
   int          checks = 0, errors = 0;
   int          exp_seq1 = 0, exp_seq2 = 0;

   always #5 clk = ~clk;

   sd_seq_burst_gen #(.width(8), .tag_sz(1), .tag_val(0), .burst_len(4), .gap_cycles(2)) dut1 (
      .clk(clk), .reset(reset), .go(go1), .count(count),
`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
      .err_inj(errinj),
`endif
      .p_srdy(srdy1), .p_drdy(p_drdy), .p_data(data1), .busy(busy1), .done(done1));

   sd_seq_burst_gen #(.width(4), .tag_sz(1), .tag_val(1), .burst_len(4), .gap_cycles(2)) dut2 (
      .clk(clk), .reset(reset), .go(go2), .count(count),
`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
      .err_inj(1'b0),
`endif
      .p_srdy(srdy2), .p_drdy(p_drdy), .p_data(data2), .busy(busy2), .done(done2));

   function automatic logic [7:0] exp_data(input bit sel);
      logic [7:0] s1, s2;
      s1 = 8'(exp_seq1);
      s2 = 8'(exp_seq2);
      return sel ? {4'b0, 1'b1, s2[2:0]} : {1'b0, s1[6:0]};
   endfunction

   task automatic run_seq(input bit sel, input int cnt, input int mode, input int stray_at, input int err_at);
      int n;
      bit seen_done, prev_s, prev_r;
      logic [7:0] prev_d, d;
      logic s, dn, b;
      n = 0; seen_done = 0; prev_s = 0; prev_r = 1; prev_d = '0;
      @(negedge clk);
      count = 16'(cnt);
      if (sel) go2 = 1'b1; else go1 = 1'b1;
      p_drdy = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         @(negedge clk);
         go1 = 1'b0; go2 = 1'b0; errinj = 1'b0;
         s  = sel ? srdy2 : srdy1;
         d  = sel ? {4'b0, data2} : data1;
         dn = sel ? done2 : done1;
         b  = sel ? busy2 : busy1;
         if (c == 0) begin
            checks++;
            if (s !== 1'b1 || b !== 1'b1) begin
               errors++;
               $display("FAIL first_srdy: srdy=%b busy=%b, want 1 1", s, b);
            end
         end
         if (prev_s && !prev_r) begin
            checks++;
            if (s !== 1'b1 || d !== prev_d) begin
               errors++;
               $display("FAIL hold_stall: srdy=%b data=%h, want 1 %h", s, d, prev_d);
            end
         end
         if (dn === 1'b1) begin
            seen_done = 1;
            checks++;
            if (b !== 1'b0 || s !== 1'b0) begin
               errors++;
               $display("FAIL done_state: busy=%b srdy=%b, want 0 0", b, s);
            end
         end else begin
            case (mode)
               1:       p_drdy = (c % 2 == 0);
               2:       p_drdy = (c >= 3);
               default: p_drdy = 1'b1;
            endcase
            if (c == stray_at) begin go1 = 1'b1; count = 16'd9; end
            if (s && p_drdy) begin
               checks++;
               if (d !== exp_data(sel)) begin
                  errors++;
                  $display("FAIL xfer_data[%0d]: got %h, want %h", n, d, exp_data(sel));
               end
               errinj = (n == err_at);
               if (sel) exp_seq2 = (exp_seq2 + 1) % 8;
               else     exp_seq1 = (exp_seq1 + ((n == err_at) ? 2 : 1)) % 128;
               n++;
            end
            prev_s = s; prev_r = p_drdy; prev_d = d;
         end
      end
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL done_timeout: no done within budget, want done");
      end
      checks++;
      if (n != cnt) begin
         errors++;
         $display("FAIL xfer_count: got %0d, want %0d", n, cnt);
      end
      @(negedge clk);
      p_drdy = 1'b0;
      checks++;
      if ((sel ? done2 : done1) !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: done still 1, want 0");
      end
   endtask

   task automatic test_reset;
      checks++;
      if (srdy1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || data1 !== 8'h00) begin
         errors++;
         $display("FAIL reset1: srdy=%b busy=%b done=%b data=%h, want 0 0 0 00", srdy1, busy1, done1, data1);
      end
      checks++;
      if (srdy2 !== 1'b0 || data2 !== 4'h8) begin
         errors++;
         $display("FAIL reset2: srdy=%b data=%h, want 0 8", srdy2, data2);
      end
   endtask

   task automatic test_basic_burst;
      int es[9]  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
      int ed[9]  = '{0, 1, 2, 3, 0, 0, 4, 0, 0};
      int edn[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      int eb[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      @(negedge clk);
      count = 16'd5; go1 = 1'b1; p_drdy = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         go1 = 1'b0;
         checks++;
         if (srdy1 !== es[c][0] || done1 !== edn[c][0] || busy1 !== eb[c][0] ||
             (es[c] == 1 && data1 !== 8'(ed[c]))) begin
            errors++;
            $display("FAIL basic_burst[%0d]: srdy=%b done=%b busy=%b data=%h, want %0d %0d %0d %0d",
                     c, srdy1, done1, busy1, data1, es[c], edn[c], eb[c], ed[c]);
         end
      end
      p_drdy = 1'b0;
      exp_seq1 = 5;
   endtask

   task automatic test_backpressure;
      run_seq(0, 8, 1, -1, -1);
   endtask

   task automatic test_wrap;
      run_seq(1, 10, 0, -1, -1);
      checks++;
      if (data2 !== 4'hA) begin
         errors++;
         $display("FAIL wrap_final: data=%h, want a", data2);
      end
   endtask

   task automatic test_zero_count;
      @(negedge clk);
      count = 16'd0; go1 = 1'b1;
      @(negedge clk);
      go1 = 1'b0;
      checks++;
      if (done1 !== 1'b1 || srdy1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL zero_count: done=%b srdy=%b busy=%b, want 1 0 0", done1, srdy1, busy1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || srdy1 !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: done=%b srdy=%b, want 0 0", done1, srdy1);
      end
   endtask

   task automatic test_go_while_busy;
      run_seq(0, 3, 2, 1, -1);
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      count = 16'd6; go1 = 1'b1; p_drdy = 1'b1;
      @(negedge clk); go1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (srdy1 !== 1'b1 || data1 !== 8'(exp_seq1 + 2)) begin
         errors++;
         $display("FAIL pre_abort: srdy=%b data=%h, want 1 %h", srdy1, data1, 8'(exp_seq1 + 2));
      end
      reset = 1'b1;
      #1;
      checks++;
      if (srdy1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 8'h00) begin
         errors++;
         $display("FAIL async_abort: srdy=%b busy=%b data=%h, want 0 0 00", srdy1, busy1, data1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("FAIL abort_done: done=%b, want 0", done1);
      end
      reset = 1'b0; p_drdy = 1'b0;
      exp_seq1 = 0; exp_seq2 = 0;
      run_seq(0, 3, 0, -1, -1);
   endtask

`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
   task automatic test_errinj;
      run_seq(0, 5, 0, -1, 2);
   endtask
`endif

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_basic_burst();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_go_while_busy();
      test_reset_midrun();
`ifdef SDLIB_SEQ_GEN_ERRINJ_EN
      test_errinj();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
